imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Host-side writer for the coprocessor's instruction memory: the write port matching the core's instruction-fetch read path.
- Deserializes 4-bit nibbles from spare pad inputs (io_in[7:2]) into 32-bit instruction words and writes them to sequential IMem addresses starting at 0.
- Holds the core in reset (cpu_run low) until a complete program has been loaded.
- Sits between the top-level pads and the IMem write port.

Parameters:
AW, 8, IMem address width (matches the 8-bit instruction counter)
DW, 32, instruction word width; must be a multiple of 4
NPW, DW/4, nibbles per word (derived; do not override)

Ports:
clock  input  1  system clock (io_in[0])
reset  input  1  synchronous, active-high reset (io_in[1])
ld_start  input  1  begin a load session (io_in[2])
ld_valid  input  1  ld_nib is valid this cycle (io_in[3])
ld_nib  input  4  data nibble, MS nibble first (io_in[7:4])
wr_en  output  1  IMem write strobe, one-cycle pulse
wr_addr  output  AW  IMem write address
wr_data  output  DW  IMem write data
busy  output  1  high in HDR/DATA states
cpu_run  output  1  releases the core: drives the PC enable and the core's reset deassert
err  output  1  load failed; sticky until ld_start or reset

Behaviour:
- Reset values (synchronous, active-high): state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, cpu_run=0, err=0, nibble counter=0, word counter=0.
- A nibble is accepted on any rising edge where ld_valid=1 and state is HDR, DATA or CKS. ld_valid in IDLE/DONE/ERR is ignored.
- IDLE: ld_start=1 -> HDR. Clears wr_addr, counters and err; cpu_run goes low.
- HDR: accepts 2 nibbles (MS first) forming word count WC. WC=0 means 2^AW words. After the 2nd nibble -> DATA.
- DATA: shifts nibbles into a DW-bit shift register, MS nibble first.
  - On acceptance of nibble NPW, the next edge registers wr_data = assembled word and pulses wr_en=1 for exactly one cycle at the current wr_addr.
  - wr_addr increments on the edge after the pulse.
  - There is no dead cycle: a nibble presented during the wr_en cycle is accepted as nibble 1 of the next word.
- After word WC is written -> DONE (or CKS when LOADER_CHECKSUM_EN is defined).
- DONE: cpu_run=1, busy=0. cpu_run stays high until ld_start or reset.
- ld_start while busy: ignored. ld_start in DONE or ERR: behaves as in IDLE (restart, cpu_run drops the same edge).
- wr_addr never wraps within a session: WC≤2^AW, and the final increment after address 2^AW-1 returns it to 0 harmlessly in DONE.
- Reset mid-session: everything returns to reset values the next edge. A partially assembled word is discarded, and no wr_en pulse follows.
- Reset and ld_start asserted together: reset wins.
- Gaps in ld_valid are allowed anywhere; the FSM stalls with no timeout.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit sum (mod 256) covers every accepted data byte, i.e. each nibble pair within a word; header excluded.
  - After the last word, CKS state accepts 2 nibbles (MS first).
  - Match -> DONE. Mismatch -> ERR: err=1, cpu_run stays 0. Already-written words remain in IMem.
- Undefined: there is no CKS/ERR state and err is tied to 0. The last word goes directly to DONE.

Decomposition:
- Shared package cnn_loader_pkg holds:
  - state encoding localparams: IDLE=0, HDR=1, DATA=2, CKS=3, DONE=4, ERR=5;
  - NIB_W=4;
  - pad bit-index constants for io_in (START=2, VALID=3, NIB_LSB=4).
- One sub-module is natural: nib_deser. It is the DW-bit nibble shift register plus nibble counter, with a word_done pulse output.
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Load of 2 words: reset; ld_start; header nibbles 0,2; data nibbles 1..8 then A,B,C,D,E,F,0,1 -> wr_en at addr 0 with 0x12345678, at addr 1 with 0xABCDEF01; then cpu_run=1, busy=0.
- Back-to-back: ld_valid held at 1 continuously for a 3-word load -> three wr_en pulses spaced exactly 8 cycles apart, at addrs 0,1,2, with no lost nibbles.
- WC=0: header 0,0 followed by 256 words -> last write at addr 0xFF, then DONE; no wr_en at any other time.
- Mid-load reset: reset asserted after 5 nibbles of word 1 -> next edge all outputs return to 0, no wr_en; a new session then writes starting at addr 0.
- ld_start while busy is ignored; ld_start in DONE drops cpu_run on the same edge and starts a new header.
- LOADER_CHECKSUM_EN, word 0x12345678: sum 0x12+0x34+0x56+0x78=0x14. Checksum nibbles 1,4 -> DONE with cpu_run=1. Checksum nibbles 1,5 -> err=1 and cpu_run=0.

Source files
------------

// File: rtl/cnn_loader_pkg.sv
// rtl/cnn_loader_pkg.sv - shared encodings and constants for the instruction memory loader
package cnn_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CKS  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int NIB_W = 4;

    // Bit positions of the loader signals on the spare pad bus io_in
    localparam int PAD_START   = 2;
    localparam int PAD_VALID   = 3;
    localparam int PAD_NIB_LSB = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host nibble stream in, IMem write port and core control out
interface imem_loader_if
    import cnn_loader_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic             ld_start;
    logic             ld_valid;
    logic [NIB_W-1:0] ld_nib;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             busy;
    logic             cpu_run;
    logic             err;

    modport master (
        output ld_start, ld_valid, ld_nib,
        input  wr_en, wr_addr, wr_data, busy, cpu_run, err
    );

    modport slave (
        input  ld_start, ld_valid, ld_nib,
        output wr_en, wr_addr, wr_data, busy, cpu_run, err
    );
endinterface

// File: rtl/imem_loader_nib_deser.sv
// rtl/imem_loader_nib_deser.sv - nibble shift register assembling DW-bit words, MS nibble first
module nib_deser
    import cnn_loader_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [NIB_W-1:0] nib,
    output logic [DW-1:0]    word,
    output logic             word_done
);
    localparam int NPW = DW / NIB_W;
    localparam int CW  = (NPW > 1) ? $clog2(NPW) : 1;

    // Only the first NPW-1 nibbles need storing; the last one arrives with word_done
    logic [DW-NIB_W-1:0] sh;
    logic [CW-1:0]       cnt;

    assign word      = {sh, nib};
    assign word_done = shift_en && (cnt == CW'(NPW - 1));

    // Shift in accepted nibbles and count position within the current word
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            sh  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sh  <= word[DW-NIB_W-1:0];
            cnt <= word_done ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads nibble-serial program into IMem, holds core until done; optional LOADER_CHECKSUM_EN
module imem_loader
    import cnn_loader_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic         clock,
    input  logic         reset,
    imem_loader_if.slave bus
);
    state_t        state;
    logic          hi_seen;
    logic [7:0]    wc;
    logic [AW-1:0] word_cnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] word;
    logic          wr_en;
    logic          busy;
    logic          cpu_run;
    logic          word_done;
    logic          start_ok;
    logic          shift_en;
    logic          last_word;
`ifdef LOADER_CHECKSUM_EN
    logic             err;
    logic [7:0]       sum;
    logic [NIB_W-1:0] hi_nib;
`endif

    assign start_ok  = bus.ld_start && (state == IDLE || state == DONE || state == ERR);
    assign shift_en  = (state == DATA) && bus.ld_valid;
    // WC of zero means a full 2^AW words, which the wrapping subtraction gives for free
    assign last_word = (word_cnt == AW'(wc) - AW'(1));

    nib_deser #(.DW(DW)) u_deser (
        .clock     (clock),
        .reset     (reset),
        .clr       (start_ok),
        .shift_en  (shift_en),
        .nib       (bus.ld_nib),
        .word      (word),
        .word_done (word_done)
    );

    // Session FSM, write port, address/word counters and checksum
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            cpu_run  <= 1'b0;
            hi_seen  <= 1'b0;
            wc       <= '0;
            word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            err      <= 1'b0;
            sum      <= '0;
            hi_nib   <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (start_ok) begin
                state    <= HDR;
                busy     <= 1'b1;
                cpu_run  <= 1'b0;
                wr_addr  <= '0;
                word_cnt <= '0;
                hi_seen  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                err      <= 1'b0;
                sum      <= '0;
`endif
            end else begin
                case (state)
                    HDR: begin
                        if (bus.ld_valid) begin
                            if (!hi_seen) begin
                                wc[7:4] <= bus.ld_nib;
                                hi_seen <= 1'b1;
                            end else begin
                                wc[3:0] <= bus.ld_nib;
                                hi_seen <= 1'b0;
                                state   <= DATA;
                            end
                        end
                    end
                    DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        if (bus.ld_valid) begin
                            hi_seen <= !hi_seen;
                            if (hi_seen) begin
                                sum <= sum + {hi_nib, bus.ld_nib};
                            end else begin
                                hi_nib <= bus.ld_nib;
                            end
                        end
`endif
                        if (word_done) begin
                            wr_en    <= 1'b1;
                            wr_data  <= word;
                            word_cnt <= word_cnt + 1'b1;
                            if (last_word) begin
                                busy <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                                state <= CKS;
`else
                                state   <= DONE;
                                cpu_run <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CKS: begin
                        if (bus.ld_valid) begin
                            if (!hi_seen) begin
                                hi_nib  <= bus.ld_nib;
                                hi_seen <= 1'b1;
                            end else begin
                                hi_seen <= 1'b0;
                                if ({hi_nib, bus.ld_nib} == sum) begin
                                    state   <= DONE;
                                    cpu_run <= 1'b1;
                                end else begin
                                    state <= ERR;
                                    err   <= 1'b1;
                                end
                            end
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.busy    = busy;
    assign bus.cpu_run = cpu_run;
`ifdef LOADER_CHECKSUM_EN
    assign bus.err     = err;
`else
    assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [39:0] exp_q[$];
    int          wr_times[$];
    logic [31:0] pw[256];

    imem_loader_if #(.AW(8), .DW(32)) bus ();

    imem_loader #(.AW(8), .DW(32)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected (addr, data)
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            logic [39:0] e;
            wr_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: addr 0x%0h data 0x%0h with nothing expected", bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.wr_addr), 64'(e[39:32]));
                check("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},   64'(bus.wr_en),   0);
        check({tag, "_wr_addr"}, 64'(bus.wr_addr), 0);
        check({tag, "_wr_data"}, 64'(bus.wr_data), 0);
        check({tag, "_busy"},    64'(bus.busy),    0);
        check({tag, "_cpu_run"}, 64'(bus.cpu_run), 0);
        check({tag, "_err"},     64'(bus.err),     0);
    endtask

    task automatic send_nib(input logic [3:0] n, input bit gaps);
        bus.ld_valid = 1'b1;
        bus.ld_nib   = n;
        @(posedge clk);
        #1;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.ld_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic start_session();
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'b1;
        @(posedge clk);
        #1;
        bus.ld_start = 1'b0;
        check("start_busy", 64'(bus.busy), 1);
        check("start_cpu_run", 64'(bus.cpu_run), 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pw[i] = $urandom;
    endtask

    // Header, words and (optionally) checksum for one session, then end-state checks
    task automatic body(input int wc, input bit gaps, input bit midstart, input bit cks_good);
        int         n;
        logic [7:0] sum;
        logic [7:0] c;
        logic [7:0] hdr;
        bit         exp_err;
        n   = (wc == 0) ? 256 : wc;
        sum = 8'd0;
        hdr = 8'(wc);
        send_nib(hdr[7:4], gaps);
        send_nib(hdr[3:0], gaps);
        if (midstart) begin
            bus.ld_valid = 1'b0;
            bus.ld_start = 1'b1;
            @(posedge clk);
            #1;
            bus.ld_start = 1'b0;
            check("start_while_busy", 64'(bus.busy), 1);
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), pw[i]});
            sum = sum + pw[i][31:24] + pw[i][23:16] + pw[i][15:8] + pw[i][7:0];
            for (int k = 7; k >= 0; k--) send_nib(pw[i][k*4 +: 4], gaps);
        end
`ifdef LOADER_CHECKSUM_EN
        c = cks_good ? sum : sum + 8'(1 + $urandom_range(0, 254));
        send_nib(c[7:4], gaps);
        send_nib(c[3:0], gaps);
        exp_err = !cks_good;
`else
        c = sum;
        exp_err = 1'b0;
        if (!cks_good) $display("note: checksum build not enabled, value %0h unused", c);
`endif
        bus.ld_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("end_cpu_run", 64'(bus.cpu_run), 64'(!exp_err));
        check("end_busy", 64'(bus.busy), 0);
        check("end_err", 64'(bus.err), 64'(exp_err));
        check("queue_drained", 64'(exp_q.size()), 0);
    endtask

    initial begin
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_nib   = 4'd0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Directed two-word load
        pw[0] = 32'h12345678;
        pw[1] = 32'hABCDEF01;
        start_session();
        body(2, 0, 0, 1);

        // ld_valid outside a session is ignored
        for (int i = 0; i < 4; i++) send_nib(4'($urandom), 0);
        bus.ld_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_valid_cpu_run", 64'(bus.cpu_run), 1);

        // Back-to-back three-word load, ld_valid held high throughout
        fill_random(3);
        start_session();
        wr_times.delete();
        body(3, 0, 0, 1);
        check("b2b_pulses", 64'(wr_times.size()), 3);
        if (wr_times.size() == 3) begin
            check("b2b_gap0", 64'(wr_times[1] - wr_times[0]), 8);
            check("b2b_gap1", 64'(wr_times[2] - wr_times[1]), 8);
        end

        // Restart from DONE, with a stray ld_start while busy
        fill_random(6);
        start_session();
        body($urandom_range(1, 6), 1, 1, 1);

        // Reset part-way through the second word, with ld_start also high
        fill_random(2);
        start_session();
        exp_q.push_back({8'd0, pw[0]});
        send_nib(4'h0, 0);
        send_nib(4'h2, 0);
        for (int k = 7; k >= 0; k--) send_nib(pw[0][k*4 +: 4], 0);
        for (int k = 7; k >= 3; k--) send_nib(pw[1][k*4 +: 4], 0);
        bus.ld_valid = 1'b0;
        reset        = 1'b1;
        bus.ld_start = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        reset        = 1'b0;
        bus.ld_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_drained", 64'(exp_q.size()), 0);
        check("midreset_idle_busy", 64'(bus.busy), 0);

        fill_random(4);
        start_session();
        body(4, 1, 0, 1);

        // Full 256-word load from header 0,0
        fill_random(256);
        start_session();
        body(0, 1, 0, 1);
        check("wc0_addr_wrapped", 64'(bus.wr_addr), 0);

`ifdef LOADER_CHECKSUM_EN
        // Directed checksum pass (0x14) and fail
        pw[0] = 32'h12345678;
        start_session();
        body(1, 0, 0, 1);
        start_session();
        body(1, 0, 0, 0);
        start_session();
        check("err_cleared_on_start", 64'(bus.err), 0);
        fill_random(3);
        body(3, 1, 0, 0);
        start_session();
        body(2, 1, 0, 1);
`endif

        // A few fully random sessions
        for (int s = 0; s < 3; s++) begin
            int w;
            w = $urandom_range(1, 12);
            fill_random(w);
            start_session();
            body(w, 1, ($urandom_range(0, 1) == 1), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
